axis_rr_arbiter: RTL and testbench

Round-robin arbiter merging `N_SRC` AXI-Stream producers (`axis_pe` instances) onto one AXI-Stream output. Each grant lasts a fixed burst of `BURST` beats, or less if the granted source signals `done` first. The block sits between the PE array and the single downstream consumer. It raises its own `done` once every source has finished.

---
 rtl/axis_arb_pkg.sv | 32 +++
 rtl/axis_rr_picker.sv | 24 ++
 rtl/axis_rr_arbiter.sv | 113 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared arbitration types and the rotate-priority pick used by the stream arbiters.
package axis_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int RR_MAX_SRC = 64;

    // First set bit of elig scanning ptr+1, ptr+2, ... modulo n; 0 when none is set.
    function automatic int rr_next(
        input logic [RR_MAX_SRC-1:0] elig,
        input int                    ptr,
        input int                    n
    );
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 1; i <= RR_MAX_SRC; i++) begin
            idx = (ptr + i) % n;
            if (i <= n && !found && elig[idx[5:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin pick over the eligible sources, starting after ptr.
module axis_rr_picker
    import axis_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    logic [RR_MAX_SRC-1:0] elig_wide;

    always_comb begin
        elig_wide              = '0;
        elig_wide[N_SRC-1:0]   = eligible;
    end

    assign grant_idx = ID_W'(rr_next(elig_wide, int'(ptr), N_SRC));
    assign any       = |eligible;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of N_SRC AXI-Stream producers, bursts of up to BURST beats per grant.
//   state  | meaning
//   IDLE   | bubble cycle: pick next eligible source after ptr, track all-done
//   STREAM | forward source sel until BURST beats or its done with no beat
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int D_W   = 32,
    parameter  int N_SRC = 4,
    parameter  int BURST = 8,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       s_axis_valid,
    input  logic [N_SRC*D_W-1:0]   s_axis_data,
    output logic [N_SRC-1:0]       s_axis_ready,
    input  logic [N_SRC-1:0]       s_done,
    output logic                   m_axis_valid,
    output logic [D_W-1:0]         m_axis_data,
    output logic [ID_W-1:0]        m_axis_id,
    output logic                   m_axis_last,
    input  logic                   m_axis_ready,
    output logic                   done
);

    localparam int                CNT_W    = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST - 1);
    localparam logic [ID_W-1:0]   PTR_RST  = ID_W'(N_SRC - 1);

    state_t            state, state_n;
    logic [ID_W-1:0]   sel, sel_n, ptr, ptr_n, grant_idx;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              done_r, done_n;
    logic              any_elig, streaming, xfer;

    axis_rr_picker #(.N_SRC(N_SRC), .ID_W(ID_W)) u_picker (
        .eligible  (s_axis_valid & ~s_done),
        .ptr       (ptr),
        .grant_idx (grant_idx),
        .any       (any_elig)
    );

    // Gating with rst keeps any beat from being accepted in the reset cycle.
    assign streaming = (state == STREAM) && !rst;

    always_comb begin
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        if (streaming) begin
            m_axis_valid      = s_axis_valid[sel];
            m_axis_data       = s_axis_data[int'(sel)*D_W +: D_W];
            s_axis_ready[sel] = m_axis_ready;
            m_axis_last       = s_axis_valid[sel] && (cnt == CNT_LAST);
        end
    end

    assign xfer = m_axis_valid && m_axis_ready;

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        done_n  = done_r;
        case (state)
            IDLE: begin
                if (&s_done) done_n = 1'b1;
                if (any_elig) begin
                    sel_n   = grant_idx;
                    cnt_n   = '0;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                // A beat accepted alongside done still counts; only the count ends such a cycle.
                if (xfer) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_n = IDLE;
                        ptr_n   = sel;
                    end
                end else if (s_done[sel]) begin
                    state_n = IDLE;
                    ptr_n   = sel;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            ptr    <= PTR_RST;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            done_r <= done_n;
        end
    end

    assign m_axis_id = sel;
    assign done      = done_r;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter with four behavioural 16-beat producers.
module tb_axis_rr_arbiter;

    localparam int LENGTH = 16;
    localparam logic [15:0] SEED [4] = '{16'hA000, 16'hB111, 16'hC222, 16'hD333};

    logic         clk, rst;
    logic [3:0]   s_axis_valid, s_axis_ready, s_done;
    logic [127:0] s_axis_data;
    logic         m_axis_valid, m_axis_last, m_axis_ready, done;
    logic [31:0]  m_axis_data;
    logic [1:0]   m_axis_id;

    int         errors, checks;
    int         sent [4];
    logic [3:0] en, force_done;

    axis_rr_arbiter #(.D_W(32), .N_SRC(4), .BURST(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_valid (s_axis_valid),
        .s_axis_data  (s_axis_data),
        .s_axis_ready (s_axis_ready),
        .s_done       (s_done),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_id    (m_axis_id),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Producer model: data = {seed, beat index}; done is sticky once LENGTH beats are sent.
    task automatic apply_src();
        for (int i = 0; i < 4; i++) begin
            s_done[i]              = force_done[i] || (sent[i] >= LENGTH);
            s_axis_valid[i]        = en[i] && !s_done[i];
            s_axis_data[i*32 +: 32] = {SEED[i], 16'(sent[i])};
        end
    endtask

    task automatic advance();
        logic [3:0] fire;
        fire = s_axis_valid & s_axis_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (fire[i]) sent[i]++;
        apply_src();
    endtask

    task automatic reset_all();
        rst          = 1'b1;
        m_axis_ready = 1'b1;
        en           = '0;
        force_done   = '0;
        for (int i = 0; i < 4; i++) sent[i] = 0;
        apply_src();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_all();
        en = 4'hF;
        apply_src();
        @(negedge clk);
        checks++;
        if (m_axis_valid !== 1'b0 || s_axis_ready !== 4'h0 || m_axis_last !== 1'b0 ||
            m_axis_data !== 32'h0 || done !== 1'b0 || m_axis_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b ready=%b last=%b data=%h done=%b id=%0d, need all 0",
                     m_axis_valid, s_axis_ready, m_axis_last, m_axis_data, done, m_axis_id);
        end
        advance();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_axis_valid !== 1'b0 || m_axis_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_bubble: valid=%b id=%0d, need valid=0 id=0", m_axis_valid, m_axis_id);
        end
        advance();
        @(negedge clk);
        checks++;
        if (m_axis_valid !== 1'b1 || m_axis_id !== 2'd0 || m_axis_data !== {SEED[0], 16'd0}) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%b id=%0d data=%h, need 1 0 %h",
                     m_axis_valid, m_axis_id, m_axis_data, {SEED[0], 16'd0});
        end
    endtask

    task automatic test_all_valid();
        logic [1:0] exp_id;
        int         beat0;
        reset_all();
        en = 4'hF;
        apply_src();
        rst = 1'b0;
        for (int g = 0; g < 8; g++) begin
            exp_id = 2'(g % 4);
            beat0  = (g / 4) * 8;
            @(negedge clk);
            checks++;
            if (m_axis_valid !== 1'b0) begin
                errors++;
                $display("FAIL all_bubble g=%0d: valid=%b, need 0", g, m_axis_valid);
            end
            advance();
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                checks++;
                if (m_axis_valid !== 1'b1 || m_axis_id !== exp_id) begin
                    errors++;
                    $display("FAIL all_grant g=%0d b=%0d: valid=%b id=%0d, need 1 %0d",
                             g, b, m_axis_valid, m_axis_id, exp_id);
                end
                checks++;
                if (m_axis_data !== {SEED[exp_id], 16'(beat0 + b)}) begin
                    errors++;
                    $display("FAIL all_data g=%0d b=%0d: got %h, need %h",
                             g, b, m_axis_data, {SEED[exp_id], 16'(beat0 + b)});
                end
                checks++;
                if (m_axis_last !== (b == 7)) begin
                    errors++;
                    $display("FAIL all_last g=%0d b=%0d: got %b, need %b", g, b, m_axis_last, b == 7);
                end
                checks++;
                if (s_axis_ready !== (4'b0001 << exp_id)) begin
                    errors++;
                    $display("FAIL all_ready g=%0d b=%0d: got %b, need %b",
                             g, b, s_axis_ready, 4'b0001 << exp_id);
                end
                advance();
            end
        end
        @(negedge clk);
        checks++;
        if (m_axis_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL all_done_early: valid=%b done=%b, need 0 0", m_axis_valid, done);
        end
        advance();
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL all_done: got %b, need 1", done);
        end
    endtask

    task automatic test_backpressure();
        int         nxt [4];
        logic       stalled;
        logic [31:0] hdata;
        logic [1:0] hid;
        int         cyc;
        reset_all();
        en = 4'hF;
        apply_src();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) nxt[i] = 0;
        stalled = 1'b0;
        hdata   = '0;
        hid     = '0;
        cyc     = 0;
        while (done !== 1'b1 && cyc < 400) begin
            m_axis_ready = ((cyc % 5) != 4);
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (m_axis_valid !== 1'b1 || m_axis_data !== hdata || m_axis_id !== hid) begin
                    errors++;
                    $display("FAIL bp_hold cyc=%0d: valid=%b id=%0d data=%h, need 1 %0d %h",
                             cyc, m_axis_valid, m_axis_id, m_axis_data, hid, hdata);
                end
            end
            stalled = 1'b0;
            if (m_axis_valid === 1'b1 && m_axis_ready) begin
                checks++;
                if (m_axis_data !== {SEED[m_axis_id], 16'(nxt[m_axis_id])}) begin
                    errors++;
                    $display("FAIL bp_data cyc=%0d id=%0d: got %h, need %h",
                             cyc, m_axis_id, m_axis_data, {SEED[m_axis_id], 16'(nxt[m_axis_id])});
                end
                nxt[m_axis_id]++;
            end else if (m_axis_valid === 1'b1) begin
                stalled = 1'b1;
                hdata   = m_axis_data;
                hid     = m_axis_id;
            end
            advance();
            cyc++;
        end
        m_axis_ready = 1'b1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout: done=%b after %0d cycles, need 1", done, cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (nxt[i] != LENGTH) begin
                errors++;
                $display("FAIL bp_count src=%0d: got %0d beats, need %0d", i, nxt[i], LENGTH);
            end
        end
    endtask

    task automatic test_late_arrival();
        reset_all();
        en[2] = 1'b1;
        apply_src();
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            checks++;
            if (m_axis_valid !== 1'b0) begin
                errors++;
                $display("FAIL late_bubble g=%0d: valid=%b, need 0", g, m_axis_valid);
            end
            advance();
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                checks++;
                if (m_axis_valid !== 1'b1 || m_axis_id !== 2'd2 ||
                    m_axis_data !== {SEED[2], 16'(g*8 + b)}) begin
                    errors++;
                    $display("FAIL late_src2 g=%0d b=%0d: valid=%b id=%0d data=%h, need 1 2 %h",
                             g, b, m_axis_valid, m_axis_id, m_axis_data, {SEED[2], 16'(g*8 + b)});
                end
                advance();
                if (g == 1 && b == 2) begin
                    en[0] = 1'b1;
                    apply_src();
                end
            end
        end
        @(negedge clk);
        checks++;
        if (m_axis_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_bubble2: valid=%b, need 0", m_axis_valid);
        end
        advance();
        @(negedge clk);
        checks++;
        if (m_axis_valid !== 1'b1 || m_axis_id !== 2'd0 || m_axis_data !== {SEED[0], 16'd0}) begin
            errors++;
            $display("FAIL late_src0: valid=%b id=%0d data=%h, need 1 0 %h",
                     m_axis_valid, m_axis_id, m_axis_data, {SEED[0], 16'd0});
        end
    endtask

    task automatic test_early_done();
        logic [1:0] seq_id [5];
        int         seq_b0 [5];
        seq_id = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        seq_b0 = '{0, 0, 8, 8, 8};
        reset_all();
        en = 4'hF;
        apply_src();
        rst = 1'b0;
        @(negedge clk);
        advance();
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            advance();
        end
        @(negedge clk);
        advance();
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            checks++;
            if (m_axis_valid !== 1'b1 || m_axis_id !== 2'd1 || m_axis_last !== 1'b0) begin
                errors++;
                $display("FAIL early_src1 b=%0d: valid=%b id=%0d last=%b, need 1 1 0",
                         b, m_axis_valid, m_axis_id, m_axis_last);
            end
            advance();
        end
        force_done[1] = 1'b1;
        apply_src();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (m_axis_valid !== 1'b0) begin
                errors++;
                $display("FAIL early_release k=%0d: valid=%b, need 0", k, m_axis_valid);
            end
            advance();
        end
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                checks++;
                if (m_axis_valid !== 1'b1 || m_axis_id !== seq_id[g] ||
                    m_axis_data !== {SEED[seq_id[g]], 16'(seq_b0[g] + b)}) begin
                    errors++;
                    $display("FAIL early_seq g=%0d b=%0d: valid=%b id=%0d data=%h, need 1 %0d %h",
                             g, b, m_axis_valid, m_axis_id, m_axis_data, seq_id[g],
                             {SEED[seq_id[g]], 16'(seq_b0[g] + b)});
                end
                advance();
            end
            @(negedge clk);
            checks++;
            if (m_axis_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL early_gap g=%0d: valid=%b done=%b, need 0 0", g, m_axis_valid, done);
            end
            advance();
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || m_axis_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_done: done=%b valid=%b, need 1 0", done, m_axis_valid);
        end
    endtask

    task automatic test_mid_reset();
        reset_all();
        en = 4'hF;
        apply_src();
        rst = 1'b0;
        @(negedge clk);
        advance();
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            advance();
        end
        @(negedge clk);
        advance();
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            advance();
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m_axis_valid !== 1'b0 || s_axis_ready !== 4'h0) begin
            errors++;
            $display("FAIL midrst_gate: valid=%b ready=%b, need 0 0000", m_axis_valid, s_axis_ready);
        end
        advance();
        rst = 1'b0;
        checks++;
        if (sent[1] != 3) begin
            errors++;
            $display("FAIL midrst_no_accept: src1 beats=%0d, need 3", sent[1]);
        end
        @(negedge clk);
        checks++;
        if (m_axis_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: valid=%b, need 0", m_axis_valid);
        end
        advance();
        @(negedge clk);
        checks++;
        if (m_axis_valid !== 1'b1 || m_axis_id !== 2'd0 || m_axis_data !== {SEED[0], 16'd8}) begin
            errors++;
            $display("FAIL midrst_regrant: valid=%b id=%0d data=%h, need 1 0 %h",
                     m_axis_valid, m_axis_id, m_axis_data, {SEED[0], 16'd8});
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_all_valid();
        test_backpressure();
        test_late_arrival();
        test_early_done();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
